// File: rtl/xm23_pkg.sv
// Shared XM-23 datapath types: PSW layout, writeback queue entry and queue states.
package xm23_pkg;

    localparam int DATA_W = 16;
    localparam int DST_W  = 3;

    localparam int PSW_C = 0;
    localparam int PSW_Z = 1;
    localparam int PSW_N = 2;
    localparam int PSW_V = 3;

    typedef struct packed {
        logic v;
        logic n;
        logic z;
        logic c;
    } psw_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DST_W-1:0]  dst;
        logic              wr_en;
    } wb_entry_t;

    localparam logic [1:0] Q_EMPTY = 2'd0;
    localparam logic [1:0] Q_ONE   = 2'd1;
    localparam logic [1:0] Q_TWO   = 2'd2;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry in-order writeback queue; head is always held in r_head so outputs come straight from flops.
module wb_skid_fifo
    import xm23_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  wb_entry_t  i_entry,
    output logic       o_valid,
    input  logic       i_ready,
    output wb_entry_t  o_entry,
    output logic [1:0] o_state
);

    // Handshake: a beat moves on a side only in a cycle where its valid and ready are both 1;
    // ready never depends on the same-cycle valid, and o_entry holds while o_valid && !i_ready.
    logic [1:0] r_state;
    wb_entry_t  r_head;
    wb_entry_t  r_tail;
    logic       w_push;
    logic       w_pop;

    assign o_ready = (r_state != Q_TWO);
    assign o_valid = (r_state != Q_EMPTY);
    assign o_entry = r_head;
    assign o_state = r_state;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= Q_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_state)
                Q_EMPTY: begin
                    if (w_push) begin
                        r_head  <= i_entry;
                        r_state <= Q_ONE;
                    end
                end
                Q_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= i_entry;
                    end else if (w_push) begin
                        r_tail  <= i_entry;
                        r_state <= Q_TWO;
                    end else if (w_pop) begin
                        r_state <= Q_EMPTY;
                    end
                end
                Q_TWO: begin
                    // Full: no push can arrive, so the tail simply slides into the head.
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_state <= Q_ONE;
                    end
                end
                default: r_state <= Q_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/dadd_flag_commit.sv
// Execute-to-writeback stage: derives V/N/Z/C from the adder result, commits them in order,
// feeds the committed carry back to the adder, and queues results for writeback.
module dadd_flag_commit
    import xm23_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_carry,
    input  logic              ex_ovf,
    input  logic              ex_byte,
    input  logic [3:0]        ex_flag_mask,
    input  logic              ex_wr_en,
    input  logic [DST_W-1:0]  ex_dst,
    input  logic              flush,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_result,
    output logic [DST_W-1:0]  wb_dst,
    output logic              wb_wr_en,
    output logic [3:0]        psw,
    output logic              psw_carry,
    output logic [1:0]        dbg_q_state
);

    psw_t      r_psw;
    psw_t      w_flags;
    logic      w_accept;
    logic      w_fifo_ready;
    wb_entry_t w_in;
    wb_entry_t w_head;

    assign ex_ready = w_fifo_ready;
    assign w_accept = ex_valid && ex_ready && !flush;

    always_comb begin
        w_flags   = '0;
        w_flags.c = ex_carry;
        w_flags.v = ex_ovf;
        if (ex_byte) begin
            w_flags.z = (ex_result[7:0] == 8'h00);
            w_flags.n = ex_result[7];
        end else begin
            w_flags.z = (ex_result == '0);
            w_flags.n = ex_result[DATA_W-1];
        end
    end

    // Masked-off flags keep their committed value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_psw <= '0;
        end else if (w_accept) begin
            r_psw <= psw_t'((r_psw & ~ex_flag_mask) | (w_flags & ex_flag_mask));
        end
    end

    assign psw       = r_psw;
    assign psw_carry = r_psw.c;

    always_comb begin
        w_in        = '0;
        w_in.result = ex_result;
        w_in.dst    = ex_dst;
        w_in.wr_en  = ex_wr_en;
    end

    wb_skid_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_valid (ex_valid && !flush),
        .o_ready (w_fifo_ready),
        .i_entry (w_in),
        .o_valid (wb_valid),
        .i_ready (wb_ready),
        .o_entry (w_head),
        .o_state (dbg_q_state)
    );

    assign wb_result = w_head.result;
    assign wb_dst    = w_head.dst;
    assign wb_wr_en  = w_head.wr_en;

endmodule

// File: tb/tb_dadd_flag_commit.sv
// Directed and random checks of dadd_flag_commit against a queue-based reference model.
module tb_dadd_flag_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ex_result;
    logic        ex_carry;
    logic        ex_ovf;
    logic        ex_byte;
    logic [3:0]  ex_flag_mask;
    logic        ex_wr_en;
    logic [2:0]  ex_dst;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_result;
    logic [2:0]  wb_dst;
    logic        wb_wr_en;
    logic [3:0]  psw;
    logic        psw_carry;
    logic [1:0]  dbg_q_state;

    int checks   = 0;
    int failures = 0;

    logic [19:0] exp_q[$];
    logic [3:0]  m_psw = 4'b0000;

    always #5 clk = ~clk;

    dadd_flag_commit dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_result    (ex_result),
        .ex_carry     (ex_carry),
        .ex_ovf       (ex_ovf),
        .ex_byte      (ex_byte),
        .ex_flag_mask (ex_flag_mask),
        .ex_wr_en     (ex_wr_en),
        .ex_dst       (ex_dst),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_result    (wb_result),
        .wb_dst       (wb_dst),
        .wb_wr_en     (wb_wr_en),
        .psw          (psw),
        .psw_carry    (psw_carry),
        .dbg_q_state  (dbg_q_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [15:0] res, input logic c, input logic o,
                          input logic b, input logic [3:0] m, input logic w, input logic [2:0] d);
        ex_valid = v; ex_result = res; ex_carry = c; ex_ovf = o;
        ex_byte = b; ex_flag_mask = m; ex_wr_en = w; ex_dst = d;
    endtask

    task automatic check_model(input string tag);
        logic [19:0] head;
        chk({tag, ".wb_valid"}, wb_valid, exp_q.size() != 0);
        chk({tag, ".ex_ready"}, ex_ready, exp_q.size() < 2);
        chk({tag, ".psw"}, psw, m_psw);
        chk({tag, ".psw_carry"}, psw_carry, m_psw[0]);
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            chk({tag, ".wb_entry"}, {wb_result, wb_dst, wb_wr_en}, head);
        end
    endtask

    // One clock: check the model at the falling edge, then apply the spec rules at the rising edge.
    task automatic tick(input string tag);
        logic       acc;
        logic       pop;
        logic [3:0] f;
        @(negedge clk);
        check_model(tag);
        acc = ex_valid && (exp_q.size() < 2) && !flush;
        pop = (exp_q.size() != 0) && wb_ready;
        f[0] = ex_carry;
        f[3] = ex_ovf;
        f[1] = ex_byte ? (ex_result[7:0] == 8'd0) : (ex_result == 16'd0);
        f[2] = ex_byte ? ex_result[7] : ex_result[15];
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_psw = 4'b0000;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back({ex_result, ex_dst, ex_wr_en});
                m_psw = (m_psw & ~ex_flag_mask) | (f & ex_flag_mask);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
        set_ex(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 3'd7);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.wb_valid", wb_valid, 1'b0);
        chk("reset.ex_ready", ex_ready, 1'b1);
        chk("reset.psw", psw, 4'b0000);
        chk("reset.psw_carry", psw_carry, 1'b0);
        chk("reset.wb_result", wb_result, 16'h0000);
        chk("reset.wb_dst", wb_dst, 3'd0);
        chk("reset.wb_wr_en", wb_wr_en, 1'b0);
        rst = 1'b0;

        set_ex(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 3'd1);
        tick("word1000");
        chk("word1000.psw", psw, 4'b0000);
        chk("word1000.wb_result", wb_result, 16'h1000);
        chk("word1000.wb_valid", wb_valid, 1'b1);

        set_ex(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 3'd2);
        tick("dadd9999");
        chk("dadd9999.psw", psw, 4'b0011);
        chk("dadd9999.psw_carry", psw_carry, 1'b1);
        set_ex(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 3'd3);
        tick("mask_c");
        chk("mask_c.psw", psw, 4'b0010);

        set_ex(1'b1, 16'h1280, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 3'd4);
        tick("byte1280");
        chk("byte1280.psw", psw, 4'b0100);
        set_ex(1'b1, 16'h1200, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 3'd4);
        tick("byte1200");
        chk("byte1200.psw", psw, 4'b0010);
        set_ex(1'b1, 16'h1200, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 3'd5);
        tick("word1200");
        chk("word1200.psw", psw, 4'b0000);
        ex_valid = 1'b0;
        tick("drain0");
        tick("drain1");

        wb_ready = 1'b0;
        set_ex(1'b1, 16'h0A0A, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd1);
        tick("bp_a");
        set_ex(1'b1, 16'h0B0B, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd2);
        tick("bp_b");
        set_ex(1'b1, 16'h0C0C, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd3);
        chk("bp_c.ex_ready", ex_ready, 1'b0);
        tick("bp_c_stall");
        chk("bp_hold.wb_result", wb_result, 16'h0A0A);
        wb_ready = 1'b1;
        tick("bp_pop_a");
        chk("bp_pop_a.wb_result", wb_result, 16'h0B0B);
        tick("bp_push_c");
        chk("bp_push_c.wb_result", wb_result, 16'h0C0C);
        ex_valid = 1'b0;
        tick("bp_pop_c");
        chk("bp_empty.wb_valid", wb_valid, 1'b0);

        wb_ready = 1'b0;
        set_ex(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 3'd6);
        tick("fl_old");
        flush = 1'b1;
        set_ex(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 3'd7);
        tick("fl_kill");
        chk("fl_kill.psw", psw, 4'b0001);
        chk("fl_kill.wb_result", wb_result, 16'h5555);
        wb_ready = 1'b1;
        tick("fl_kill_pop");
        flush = 1'b0; ex_valid = 1'b0;
        chk("fl_drained.wb_valid", wb_valid, 1'b0);

        wb_ready = 1'b0;
        set_ex(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 3'd1);
        tick("full_a");
        set_ex(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 3'd2);
        tick("full_b");
        chk("full.psw", psw, 4'b1111);
        chk("full.ex_ready", ex_ready, 1'b0);
        rst = 1'b1;
        set_ex(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 3'd3);
        tick("mid_rst");
        chk("mid_rst.wb_valid", wb_valid, 1'b0);
        chk("mid_rst.ex_ready", ex_ready, 1'b1);
        chk("mid_rst.psw", psw, 4'b0000);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            set_ex($urandom_range(0, 9) < 7, 16'($urandom_range(0, 65535)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) ex_result = ex_result & 16'hFF00;
            if ($urandom_range(0, 5) == 0) ex_result = 16'h0000;
            flush    = ($urandom_range(0, 9) == 0);
            wb_ready = ($urandom_range(0, 9) < 6);
            rst      = ($urandom_range(0, 99) < 2);
            tick("rand");
        end
        rst = 1'b0; ex_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
        tick("final0");
        tick("final1");
        tick("final2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dadd_flag_commit.md
# dadd_flag_commit

Execute-to-writeback stage placed directly downstream of the BCD/ALU adder. Latches each adder result with its destination. Computes the PSW flags (V, N, Z, C) with word/byte rules and commits them in program order. Returns the committed carry to the adder as its next `carry_in`, and buffers results in a 2-entry queue so that writeback back-pressure does not stall flag generation.

## Interface
- `DATA_W`, 16, result width (word)
- `DST_W`, 3, register-file destination index width (R0–R7)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset: synchronous, active-high
- `ex_valid`  in  1  execute stage presents a result this cycle
- `ex_ready`  out  1  stage can accept (queue not full)
- `ex_result`  in  DATA_W  adder result (upper byte already merged upstream for .B ops)
- `ex_carry`  in  1  adder carry out (digit-1 carry for .B, digit-3 carry for .W)
- `ex_ovf`  in  1  overflow from execute; DADD drives 0
- `ex_byte`  in  1  1 = byte operation (.B)
- `ex_flag_mask`  in  4  per-flag update enable {V,N,Z,C}
- `ex_wr_en`  in  1  result is written to register file
- `ex_dst`  in  DST_W  destination register
- `flush`  in  1  kill this cycle's ex-side transfer
- `wb_valid`  out  1  queue head valid
- `wb_ready`  in  1  writeback consumes head
- `wb_result`  out  DATA_W  head result
- `wb_dst`  out  DST_W  head destination
- `wb_wr_en`  out  1  head write enable
- `psw`  out  4  committed flags {V,N,Z,C}
- `psw_carry`  out  1  `psw[0]`, wired to adder `carry_in`

## Operation
- Accept when `ex_valid && ex_ready && !flush`.
- Flags computed from the accepted input:
  - C = `ex_carry`
  - V = `ex_ovf`
  - Word: Z = (`ex_result` == 0), N = `ex_result[15]`
  - Byte: Z = (`ex_result[7:0]` == 0), N = `ex_result[7]`
- On accept, each PSW bit whose mask bit is 1 takes its computed value; masked-off bits hold. Mask 0 leaves PSW unchanged.
- On accept, the entry {result, dst, wr_en} is pushed to the queue tail. Entries with `ex_wr_en=0` are still queued, to keep order.
- Flush with `ex_valid`:
  - no push, no PSW change
  - entries already queued are unaffected and drain normally
- Queue occupancy FSM:
  - EMPTY: push → ONE
  - ONE: push only → TWO; pop only → EMPTY; push+pop → ONE
  - TWO: pop → ONE. `ex_ready`=0 in TWO, so push is impossible.
- Pop when `wb_valid && wb_ready`. FIFO order is strict.

## Timing
- Reset values: FSM EMPTY; `wb_valid`=0; `ex_ready`=1; `psw`=4'b0000; `psw_carry`=0; `wb_result`=0; `wb_dst`=0; `wb_wr_en`=0.
- `ex_ready` = (state != TWO), decoded from registered state only, so there is no combinational path from `wb_ready`.
- Latency from accept at edge N:
  - `psw` and `psw_carry` update at edge N+1, so a back-to-back DADD issued in cycle N+1 sees the new carry.
  - The entry appears at the head after edge N+1 if the queue was EMPTY. If ONE was being popped in cycle N, the new entry is head after edge N+1.
- Throughput: one accept per cycle while `wb_ready`=1.
- `rst` asserted mid-operation discards all queued entries and clears PSW at that edge. Simultaneous `ex_valid` is ignored.
- Simultaneous `flush` and `wb_ready` pop: pop proceeds, push is suppressed.
- Outputs are held stable while `wb_valid && !wb_ready`.

## Structure
- Shared package `xm23_pkg`:
  - `psw_t` packed struct {v,n,z,c}
  - PSW bit-index constants
  - `wb_entry_t` struct {result, dst, wr_en}
  - `DATA_W`/`DST_W` constants
- One sub-module: `wb_skid_fifo`, a 2-entry `wb_entry_t` queue with the EMPTY/ONE/TWO FSM and valid/ready ports. Flag logic and the PSW register stay in the top.

## Test plan
- Word result 0x1000, carry 0, mask 4'b1111 → next cycle `psw`=0000, `wb_result`=0x1000, `wb_valid`=1.
- Result 0x0000, carry 1 (9999+0001) → `psw`=0011 (Z,C), `psw_carry`=1. A back-to-back second entry with mask 4'b0001 and carry 0 → `psw`=0010.
- Byte result 0x1280 → N=1, Z=0. Byte result 0x1200 → Z=1, N=0. Word result 0x1200 → Z=0.
- `wb_ready`=0 with 3 consecutive valids (A, B, C):
  - A and B accepted
  - `ex_ready`=0 during C
  - after `wb_ready`=1, outputs A, B, then C in order, with no duplicates
- `flush` with `ex_valid` and result 0x0000, carry 1 → `psw` unchanged, no `wb_valid`; the queued older entry still drains.
- Queue TWO plus `psw`=1111, then assert `rst` → next cycle `wb_valid`=0, `ex_ready`=1, `psw`=0000.
